minn_delay_ctrl: RTL

MINN_DELAY_CTRL -- requirements
Module: minn_delay_ctrl

---
 rtl/minn_delay_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/minn_delay_ctrl.sv
// ---------------------------------------------------------------------------
// minn_delay_ctrl
//   Frame sequencer for one external minn_delay_line of matching WIDTH and
//   DEPTH. For each frame it clears the line, streams the frame in, then
//   pushes DEPTH zero samples so that every input sample emerges, and tags
//   the frame's final output sample with m_last.
//
// Parameters
//   WIDTH      signed sample width (equals the delay line's WIDTH)
//   DEPTH      delay of the attached line, must be >= 1
//   CNT_WIDTH  width of frame_cnt
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last   input sample stream
//   dl_rst          active-high synchronous reset to the delay line
//   dl_in_valid/dl_in_data          push strobe and data to the delay line
//   dl_out_valid/dl_out_data        delay line output
//   m_valid/m_data/m_last           delayed output stream, no backpressure
//   busy            controller is not idle
//   frame_cnt       completed frames, wraps
// ---------------------------------------------------------------------------
module minn_delay_ctrl #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_last,
    output logic                    dl_rst,
    output logic                    dl_in_valid,
    output logic signed [WIDTH-1:0] dl_in_data,
    input  logic                    dl_out_valid,
    input  logic signed [WIDTH-1:0] dl_out_data,
    output logic                    m_valid,
    output logic signed [WIDTH-1:0] m_data,
    output logic                    m_last,
    output logic                    busy,
    output logic [CNT_WIDTH-1:0]    frame_cnt
);

    if (DEPTH < 1) begin : g_depth_check
        $error("minn_delay_ctrl: DEPTH must be >= 1");
    end

    localparam int FCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [FCW-1:0]       r_flush_cnt;
    logic                 r_last_push;
    logic [CNT_WIDTH-1:0] r_frame_cnt;
    logic                 w_final_push;

    // Next state and delay-line drive. Reset overrides everything so the
    // line is held cleared and nothing is pushed while rst_n is low.
    always_comb begin
        w_next_state = r_state;
        s_ready      = 1'b0;
        dl_in_valid  = 1'b0;
        dl_in_data   = '0;
        dl_rst       = 1'b0;
        w_final_push = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The waiting sample is not consumed here; it is accepted
                // in RUN once the line has been cleared.
                if (s_valid) begin
                    dl_rst       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready     = 1'b1;
                dl_in_valid = s_valid;
                dl_in_data  = s_data;
                if (s_valid && s_last) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                dl_in_valid = 1'b1;
                if (r_flush_cnt == FLUSH_LAST) begin
                    w_final_push = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (!rst_n) begin
            w_next_state = ST_IDLE;
            s_ready      = 1'b0;
            dl_in_valid  = 1'b0;
            dl_in_data   = '0;
            dl_rst       = 1'b1;
            w_final_push = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
            r_last_push <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_next_state;
            // High only in the cycle after the final flush push, which is
            // exactly when the frame's last sample leaves the line.
            r_last_push <= w_final_push;
            if (r_state == ST_FLUSH && !w_final_push) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end else begin
                r_flush_cnt <= '0;
            end
            if (w_final_push) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign m_valid   = dl_out_valid;
    assign m_data    = dl_out_data;
    assign m_last    = dl_out_valid & r_last_push;
    assign busy      = (r_state != ST_IDLE);
    assign frame_cnt = r_frame_cnt;

endmodule
